// File: rtl/control_sequencer.sv
// Moore control unit: sequences fetch (T0-T2) and per-opcode execute steps (T3-T7),
// driving every register-enable, bus-source, memory and ALU-select strobe of the datapath.
module control_sequencer #(
  parameter logic [4:0] ADD_OP = 5'd3,
  parameter int         OP_W   = 6
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            stop,
  input  logic [31:0]     IR_data_out,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            PCout,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            HIout,
  output logic            LOout,
  output logic            InPortout,
  output logic            Cout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            HIin,
  output logic            LOin,
  output logic            ZHighIn,
  output logic            ZLowIn,
  output logic            enableOutport,
  output logic            Read,
  output logic            Write,
  output logic [OP_W-1:0] operation,
  output logic            run,
  output logic [3:0]      state_dbg_o
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] opcode;
  logic       is_ld, is_ldi, is_st, is_mem, is_r, is_i, is_md, is_halt;
  logic       last_step;

  assign opcode  = IR_data_out[31:27];
  assign is_ld   = (opcode == 5'd0);
  assign is_ldi  = (opcode == 5'd1);
  assign is_st   = (opcode == 5'd2);
  assign is_mem  = is_ld | is_ldi | is_st;
  assign is_r    = (opcode >= 5'd3) && (opcode <= 5'd11);
  assign is_i    = (opcode >= 5'd12) && (opcode <= 5'd14);
  assign is_md   = (opcode == 5'd15) || (opcode == 5'd16);
  assign is_halt = (opcode == 5'd27);

  assign state_dbg_o = state_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_RST;
    else     state_q <= state_d;
  end

  // Instructions not in any multi-step class (in/out/mfhi/mflo/nop/undefined) end at T3.
  always_comb begin
    last_step = 1'b0;
    case (state_q)
      S_T3:    last_step = !(is_mem | is_r | is_i | is_md);
      S_T5:    last_step = is_ldi | is_r | is_i;
      S_T6:    last_step = is_md;
      S_T7:    last_step = 1'b1;
      default: last_step = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = S_T4;
      S_T4:   state_d = S_T5;
      S_T5:   state_d = S_T6;
      S_T6:   state_d = S_T7;
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    if (last_step) state_d = stop ? S_HALT : S_T0;
    if (state_q == S_T3 && is_halt) state_d = S_HALT;
  end

  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
    LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; HIin = 1'b0; LOin = 1'b0;
    ZHighIn = 1'b0; ZLowIn = 1'b0; enableOutport = 1'b0; Read = 1'b0; Write = 1'b0;
    operation = '0;
    run = (state_q != S_RST) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_r | is_i) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_md) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else begin
          case (opcode)
            5'd22:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            5'd23:   begin Gra = 1'b1; Rout = 1'b1; enableOutport = 1'b1; end
            5'd24:   begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            5'd25:   begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        ZLowIn = 1'b1;
        if (is_mem) begin
          Cout = 1'b1; operation = OP_W'({1'b0, ADD_OP});
        end else if (is_r) begin
          Grc = 1'b1; Rout = 1'b1; operation = OP_W'({1'b0, opcode});
        end else if (is_i) begin
          Cout = 1'b1; operation = OP_W'({1'b0, opcode});
        end else begin
          Grb = 1'b1; Rout = 1'b1; ZHighIn = 1'b1; operation = OP_W'({1'b0, opcode});
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_ld | is_st) MARin = 1'b1;
        else if (is_md)    LOin = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; end
      end
      S_T6: begin
        if (is_ld)      begin Read = 1'b1; MDRin = 1'b1; end
        else if (is_st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        else            begin Zhighout = 1'b1; HIin = 1'b1; end
      end
      S_T7: begin
        if (is_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else       Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: an instruction-level micro-program model feeds an
// expected queue that a single negedge process compares against every cycle.
module tb_control_sequencer;

  localparam logic [4:0] ADD_OP = 5'd3;

  localparam logic [26:0] GRA = 27'd1 << 26, GRB = 27'd1 << 25, GRC = 27'd1 << 24;
  localparam logic [26:0] RIN = 27'd1 << 23, ROUT = 27'd1 << 22, BAOUT = 27'd1 << 21;
  localparam logic [26:0] PCOUT = 27'd1 << 20, ZHIGHOUT = 27'd1 << 19, ZLOWOUT = 27'd1 << 18;
  localparam logic [26:0] MDROUT = 27'd1 << 17, HIOUT = 27'd1 << 16, LOOUT = 27'd1 << 15;
  localparam logic [26:0] INPORTOUT = 27'd1 << 14, COUT = 27'd1 << 13, PCIN = 27'd1 << 12;
  localparam logic [26:0] INCPC = 27'd1 << 11, MARIN = 27'd1 << 10, MDRIN = 27'd1 << 9;
  localparam logic [26:0] IRIN = 27'd1 << 8, YIN = 27'd1 << 7, HIIN = 27'd1 << 6;
  localparam logic [26:0] LOIN = 27'd1 << 5, ZHIGHIN = 27'd1 << 4, ZLOWIN = 27'd1 << 3;
  localparam logic [26:0] ENOUT = 27'd1 << 2, READ = 27'd1 << 1, WRITE = 27'd1;

  typedef struct {
    logic [33:0] got;
    logic [33:0] want;
    int          tag;
  } pin_t;

  logic        clk, clr, stop;
  logic [31:0] ir;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
  logic InPortout, Cout, PCin, IncPC, MARin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn;
  logic enableOutport, Read, Write, run;
  logic [5:0]  operation;
  logic [3:0]  state_dbg;
  logic [33:0] act;

  logic [33:0] exp_q[$];
  pin_t        pin_q[$];
  int          n_vec = 0;
  int          n_mis = 0;

  control_sequencer #(.ADD_OP(ADD_OP), .OP_W(6)) dut (
    .clk(clk), .clr(clr), .stop(stop), .IR_data_out(ir),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .enableOutport(enableOutport), .Read(Read), .Write(Write),
    .operation(operation), .run(run), .state_dbg_o(state_dbg)
  );

  assign act = {run, operation, Gra, Grb, Grc, Rin, Rout, BAout, PCout, Zhighout, Zlowout,
                MDRout, HIout, LOout, InPortout, Cout, PCin, IncPC, MARin, MDRin, IRin, Yin,
                HIin, LOin, ZHighIn, ZLowIn, enableOutport, Read, Write};

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: the only process that counts comparisons.
  always @(negedge clk) begin
    logic [33:0] want;
    pin_t        p;
    while (pin_q.size() > 0) begin
      p = pin_q.pop_front();
      n_vec++;
      if (p.got !== p.want) begin
        n_mis++;
        $display("FAIL pin%0d got=%h want=%h", p.tag, p.got, p.want);
      end
    end
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_vec++;
      if (act !== want) begin
        n_mis++;
        $display("FAIL cycle t=%0t state=%0d got=%h want=%h", $time, state_dbg, act, want);
      end
      n_vec++;
      if ($countones(act[20:13]) > 1 || (Read && Write)) begin
        n_mis++;
        $display("FAIL exclusive t=%0t bus=%b rd=%b wr=%b want bus<=1 and not rd&wr",
                 $time, act[20:13], Read, Write);
      end
    end
  end

  // Model: expected output words of one instruction, step by step.
  task automatic push_w(input logic [5:0] op, input logic [26:0] ctl);
    exp_q.push_back({1'b1, op, ctl});
  endtask

  task automatic push_instr(input logic [31:0] instr, output int n);
    int         base;
    logic [4:0] opc;
    logic [5:0] opw;
    base = exp_q.size();
    opc  = instr[31:27];
    opw  = {1'b0, opc};
    push_w(6'd0, PCOUT | MARIN | INCPC | ZLOWIN);
    push_w(6'd0, ZLOWOUT | PCIN | READ | MDRIN);
    push_w(6'd0, MDROUT | IRIN);
    if (opc <= 5'd2) begin
      push_w(6'd0, GRB | BAOUT | YIN);
      push_w({1'b0, ADD_OP}, COUT | ZLOWIN);
      if (opc == 5'd1) push_w(6'd0, ZLOWOUT | GRA | RIN);
      else begin
        push_w(6'd0, ZLOWOUT | MARIN);
        if (opc == 5'd0) begin
          push_w(6'd0, READ | MDRIN);
          push_w(6'd0, MDROUT | GRA | RIN);
        end else begin
          push_w(6'd0, GRA | ROUT | MDRIN);
          push_w(6'd0, WRITE);
        end
      end
    end else if (opc inside {[5'd3:5'd14]}) begin
      push_w(6'd0, GRB | ROUT | YIN);
      push_w(opw, ((opc <= 5'd11) ? (GRC | ROUT) : COUT) | ZLOWIN);
      push_w(6'd0, ZLOWOUT | GRA | RIN);
    end else if (opc == 5'd15 || opc == 5'd16) begin
      push_w(6'd0, GRA | ROUT | YIN);
      push_w(opw, GRB | ROUT | ZHIGHIN | ZLOWIN);
      push_w(6'd0, ZLOWOUT | LOIN);
      push_w(6'd0, ZHIGHOUT | HIIN);
    end else begin
      case (opc)
        5'd22:   push_w(6'd0, INPORTOUT | GRA | RIN);
        5'd23:   push_w(6'd0, GRA | ROUT | ENOUT);
        5'd24:   push_w(6'd0, HIOUT | GRA | RIN);
        5'd25:   push_w(6'd0, LOOUT | GRA | RIN);
        default: push_w(6'd0, 27'd0);
      endcase
    end
    n = exp_q.size() - base;
  endtask

  // Driver tasks: each starts just after a rising edge with the DUT in T0.
  task automatic run_instr(input logic [31:0] instr, input int exp_n, input int tag,
                           input int stop_a, input int stop_b,
                           input int probe_k, input logic [33:0] probe_w);
    int n;
    ir = instr;
    push_instr(instr, n);
    pin_q.push_back('{got: 34'(n), want: 34'(exp_n), tag: tag});
    for (int k = 0; k < n; k++) begin
      if (k == probe_k) pin_q.push_back('{got: act, want: probe_w, tag: tag + 100});
      stop = (k == stop_a) || (k == stop_b);
      @(posedge clk); #1;
    end
    stop = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('0);
      @(posedge clk); #1;
    end
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    exp_q.push_back('0);
    exp_q.push_back('0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    clr  = 1'b1;
    stop = 1'b0;
    ir   = 32'd0;
    @(posedge clk); #1;
    clr_pulse();
    pin_q.push_back('{got: act, want: {1'b1, 6'd0, PCOUT | MARIN | INCPC | ZLOWIN}, tag: 1});

    run_instr(32'h1A100000, 6, 2, -1, -1, 4, {1'b1, 6'd3, GRC | ROUT | ZLOWIN});
    run_instr(32'h00800005, 8, 3, -1, -1, 6, {1'b1, 6'd0, READ | MDRIN});
    run_instr(32'h10800000, 8, 4, -1, -1, 7, {1'b1, 6'd0, WRITE});
    run_instr(32'h78000000, 7, 5, -1, -1, 4, {1'b1, 6'd15, GRB | ROUT | ZHIGHIN | ZLOWIN});
    run_instr(32'h80000000, 7, 6, -1, -1, -1, '0);
    run_instr(32'h08000000, 6, 7, -1, -1, 4, {1'b1, 6'd3, COUT | ZLOWIN});
    run_instr(32'h60000000, 6, 8, -1, -1, 4, {1'b1, 6'd12, COUT | ZLOWIN});
    run_instr(32'h38000000, 6, 9, -1, -1, -1, '0);
    run_instr(32'hB0000000, 4, 10, -1, -1, -1, '0);
    run_instr(32'hB8000000, 4, 11, -1, -1, -1, '0);
    run_instr(32'hC0000000, 4, 12, -1, -1, -1, '0);
    run_instr(32'hC8000000, 4, 13, -1, -1, -1, '0);
    run_instr(32'hD0000000, 4, 14, -1, -1, 3, {1'b1, 33'd0});
    run_instr(32'hA0000000, 4, 15, -1, -1, -1, '0);

    // stop in T4 is ignored, stop in T5 (last step) halts
    run_instr(32'h1A100000, 6, 16, 4, 5, -1, '0);
    idle_cycles(3);
    clr_pulse();

    run_instr(32'hD8000000, 4, 17, -1, -1, -1, '0);
    idle_cycles(2);
    clr_pulse();

    run_instr(32'h00800005, 8, 18, 7, -1, -1, '0);
    idle_cycles(2);

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
